// File: rtl/mem_load_pkg.sv
// Shared definitions for the memory load controller: state encoding and
// helpers for the active-low per-bank enable vectors.
package mem_load_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_HOLD  = 3'd4,
    ST_FINISH   = 3'd5
  } state_t;

  // Upper bound on banks the helpers can address; callers truncate to their width.
  localparam int MAX_BANKS = 32;
  localparam logic [MAX_BANKS-1:0] PORT_OFF = '1;

  function automatic logic [MAX_BANKS-1:0] bank_onehot_low(input logic [4:0] bank);
    logic [MAX_BANKS-1:0] v;
    v       = PORT_OFF;
    v[bank] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/mem_load_addr_ctr.sv
// Word address and remaining-count tracker for one load/readback command.
module mem_load_addr_ctr #(
  parameter int ADDRESS_WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     step,
  input  logic [ADDRESS_WIDTH-1:0] load_addr,
  input  logic [ADDRESS_WIDTH:0]   load_count,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     last,
  output logic                     empty
);

  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH:0]   count_q, count_d;

  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    if (load) begin
      addr_d  = load_addr;
      count_d = load_count;
    end else if (step) begin
      // The wrap past the top word only happens after the final access.
      addr_d  = addr_q + 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  assign addr  = addr_q;
  assign count = count_q;
  assign last  = (count_q == (ADDRESS_WIDTH+1)'(1));
  assign empty = (count_q == '0);

endmodule

// File: rtl/mem_load_controller.sv
// Sequenced loader owning the RAM bank ports while the core is held: streams
// words into a bank (write) or out of it (readback) over valid/ready handshakes.
module mem_load_controller
  import mem_load_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 11,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_BANKS     = 2,
  parameter int BANK_WIDTH    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_read,
  input  logic [BANK_WIDTH-1:0]           cmd_bank,
  input  logic [ADDRESS_WIDTH-1:0]        cmd_addr,
  input  logic [ADDRESS_WIDTH:0]          cmd_len,
  output logic                            cmd_err,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic [NUM_BANKS-1:0]            mem_cen,
  output logic [NUM_BANKS-1:0]            mem_wen,
  output logic [NUM_BANKS-1:0]            mem_oen,
  output logic [ADDRESS_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_datain,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] mem_dataout,
  output logic                            loading,
  output logic                            done,
  output logic [2:0]                      dbg_state
);

  // Handshakes: a transfer on cmd/wr/rd happens in a cycle where valid and
  // ready are both high at the rising edge; rd_valid/rd_data hold until taken.

  localparam logic [ADDRESS_WIDTH+1:0] DEPTH = (ADDRESS_WIDTH+2)'(2**ADDRESS_WIDTH);

  state_t                  state_q, state_d;
  logic [BANK_WIDTH-1:0]   bank_q, bank_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    loading_q, loading_d;

  logic                     ctr_load, ctr_step, ctr_last, ctr_empty;
  logic [ADDRESS_WIDTH-1:0] ctr_addr;
  logic [ADDRESS_WIDTH:0]   ctr_count;
  logic [ADDRESS_WIDTH+1:0] cmd_end;
  logic                     cmd_bad;
  logic [DATA_WIDTH-1:0]    rd_sel;
  logic [NUM_BANKS-1:0]     sel_low;

  mem_load_addr_ctr #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_ctr (
    .clk        (clk),
    .rst        (rst),
    .load       (ctr_load),
    .step       (ctr_step),
    .load_addr  (cmd_addr),
    .load_count (cmd_len),
    .addr       (ctr_addr),
    .count      (ctr_count),
    .last       (ctr_last),
    .empty      (ctr_empty)
  );

  // Range check is done one bit wider than the count so it cannot wrap.
  always_comb begin
    cmd_end = (ADDRESS_WIDTH+2)'(cmd_addr) + (ADDRESS_WIDTH+2)'(cmd_len);
    cmd_bad = (cmd_len == '0) || (32'(cmd_bank) >= 32'(NUM_BANKS)) || (cmd_end > DEPTH);
  end

  always_comb begin
    rd_sel = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (32'(bank_q) == 32'(b)) rd_sel = mem_dataout[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    loading_d  = loading_q;
    ctr_load   = 1'b0;
    ctr_step   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            ctr_load  = 1'b1;
            bank_d    = cmd_bank;
            loading_d = 1'b1;
            state_d   = cmd_read ? ST_RD_ISSUE : ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (wr_valid) begin
          ctr_step = 1'b1;
          if (ctr_last) begin
            state_d   = ST_FINISH;
            done_d    = 1'b1;
            loading_d = 1'b0;
          end
        end
      end
      ST_RD_ISSUE: begin
        ctr_step = 1'b1;
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        rd_data_d  = rd_sel;
        rd_valid_d = 1'b1;
        state_d    = ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          if (ctr_empty) begin
            state_d   = ST_FINISH;
            done_d    = 1'b1;
            loading_d = 1'b0;
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bank_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      loading_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      loading_q  <= loading_d;
    end
  end

  // Port drive follows the state register, so reset releases the banks at once.
  always_comb begin
    sel_low    = NUM_BANKS'(bank_onehot_low(5'(bank_q)));
    mem_cen    = NUM_BANKS'(PORT_OFF);
    mem_wen    = NUM_BANKS'(PORT_OFF);
    mem_oen    = NUM_BANKS'(PORT_OFF);
    mem_addr   = '0;
    mem_datain = '0;
    if (state_q == ST_WRITE && wr_valid) begin
      mem_cen    = sel_low;
      mem_wen    = sel_low;
      mem_addr   = ctr_addr;
      mem_datain = wr_data;
    end else if (state_q == ST_RD_ISSUE) begin
      mem_cen  = sel_low;
      mem_oen  = sel_low;
      mem_addr = ctr_addr;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign wr_ready  = (state_q == ST_WRITE);
  assign cmd_err   = err_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign loading   = loading_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_load_controller.sv
// Directed bench for mem_load_controller with a RAM model, a write/read
// scoreboard and a shadow copy of expected memory contents.
module tb_mem_load_controller;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int NB    = 2;
  localparam int BW    = 2;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_read, cmd_err;
  logic [BW-1:0]     cmd_bank;
  logic [AW-1:0]     cmd_addr;
  logic [AW:0]       cmd_len;
  logic              wr_valid, wr_ready;
  logic [DW-1:0]     wr_data;
  logic              rd_valid, rd_ready;
  logic [DW-1:0]     rd_data;
  logic [NB-1:0]     mem_cen, mem_wen, mem_oen;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_datain;
  logic [NB*DW-1:0]  mem_dataout;
  logic              loading, done;
  logic [2:0]        dbg_state;

  logic [DW-1:0] ram    [NB][DEPTH];
  logic [DW-1:0] dout   [NB];
  logic [DW-1:0] shadow [NB][DEPTH];

  logic [63:0]   exp_wr_q[$];
  logic [DW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rd_issue_cnt = 0;
  int wr_strobe_cnt = 0;
  logic [AW-1:0] last_wr_addr;

  always #5 clk = ~clk;

  mem_load_controller #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NB), .BANK_WIDTH(BW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_err(cmd_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_oen(mem_oen),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_dataout(mem_dataout),
    .loading(loading), .done(done), .dbg_state(dbg_state)
  );

  // RAM2Kx32-style banks with one cycle of read latency.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!mem_cen[b]) begin
        if (!mem_wen[b]) ram[b][mem_addr] <= mem_datain;
        else if (!mem_oen[b]) dout[b] <= ram[b][mem_addr];
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NB; b++) mem_dataout[b*DW +: DW] = dout[b];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [1:0] wbank;
    if (!rst) begin
      if (mem_wen != '1) begin
        wr_strobe_cnt++;
        last_wr_addr = mem_addr;
        wbank = (mem_cen == 2'b10) ? 2'd0 : (mem_cen == 2'b01) ? 2'd1 : 2'd3;
        check("wr_wen_matches_cen", 64'(mem_wen), 64'(mem_cen));
        check("wr_oen_off", 64'(mem_oen), 64'(2'b11));
        check("wr_q_nonempty", 64'(exp_wr_q.size() != 0), 64'd1);
        if (exp_wr_q.size() != 0)
          check("wr_strobe", {19'd0, wbank, mem_addr, mem_datain}, exp_wr_q.pop_front());
      end else if (mem_cen != '1) begin
        rd_issue_cnt++;
      end
      if (rd_valid && rd_ready) begin
        check("rd_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        check("loading_low_at_done", 64'(loading), 64'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string p);
    check({p, "_cmd_ready"},  64'(cmd_ready),  64'd1);
    check({p, "_wr_ready"},   64'(wr_ready),   64'd0);
    check({p, "_rd_valid"},   64'(rd_valid),   64'd0);
    check({p, "_rd_data"},    64'(rd_data),    64'd0);
    check({p, "_cmd_err"},    64'(cmd_err),    64'd0);
    check({p, "_done"},       64'(done),       64'd0);
    check({p, "_loading"},    64'(loading),    64'd0);
    check({p, "_mem_cen"},    64'(mem_cen),    64'(2'b11));
    check({p, "_mem_wen"},    64'(mem_wen),    64'(2'b11));
    check({p, "_mem_oen"},    64'(mem_oen),    64'(2'b11));
    check({p, "_mem_addr"},   64'(mem_addr),   64'd0);
    check({p, "_mem_datain"}, 64'(mem_datain), 64'd0);
    check({p, "_state"},      64'(dbg_state),  64'd0);
  endtask

  // All driver tasks start and end at 1 time unit after a rising edge.
  task automatic send_cmd(input logic rd, input logic [BW-1:0] bank,
                          input logic [AW-1:0] addr, input logic [AW:0] len);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_bank  = bank;
    cmd_addr  = addr;
    cmd_len   = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic write_words(input logic [BW-1:0] bank, input logic [AW-1:0] addr,
                             input int n, input logic [DW-1:0] base,
                             input bit rand_data, input bit gaps);
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          wr_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      t = 0;
      while (!wr_ready && t < 8) begin
        @(posedge clk); #1;
        t++;
      end
      check("wr_ready_high", 64'(wr_ready), 64'd1);
      d = rand_data ? DW'($urandom) : base + DW'(i);
      a = addr + AW'(i);
      wr_valid = 1'b1;
      wr_data  = d;
      exp_wr_q.push_back({19'd0, bank, a, d});
      shadow[bank][a] = d;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    int t;
    start = done_cnt;
    t = 0;
    while (done_cnt == start && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    check("done_seen", 64'(done_cnt - start), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check("done_once", 64'(done_cnt - start), 64'd1);
    check("idle_loading_low", 64'(loading), 64'd0);
    check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  task automatic read_words(input logic [BW-1:0] bank, input logic [AW-1:0] addr,
                            input int n, input int stall_idx, input int stall_cycles);
    logic [DW-1:0] held;
    int issues0;
    int issues;
    int t;
    issues0 = rd_issue_cnt;
    for (int i = 0; i < n; i++) exp_q.push_back(shadow[bank][addr + AW'(i)]);
    send_cmd(1'b1, bank, addr, AW'(n));
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!rd_valid && t < 8) begin
        @(posedge clk); #1;
        t++;
      end
      check("rd_valid_rise", 64'(rd_valid), 64'd1);
      if (i == stall_idx) begin
        held   = rd_data;
        issues = rd_issue_cnt;
        repeat (stall_cycles) begin
          @(posedge clk); #1;
          check("rd_hold_data", 64'(rd_data), 64'(held));
          check("rd_hold_valid", 64'(rd_valid), 64'd1);
        end
        check("no_issue_in_stall", 64'(rd_issue_cnt), 64'(issues));
      end
      rd_ready = 1'b1;
      @(posedge clk); #1;
      rd_ready = 1'b0;
    end
    wait_done(16);
    check("rd_issue_count", 64'(rd_issue_cnt - issues0), 64'(n));
  endtask

  task automatic bad_cmd(input logic [BW-1:0] bank, input logic [AW-1:0] addr,
                         input logic [AW:0] len);
    int strobes;
    strobes = wr_strobe_cnt + rd_issue_cnt;
    send_cmd(1'b0, bank, addr, len);
    check("rej_err", 64'(cmd_err), 64'd1);
    check("rej_loading", 64'(loading), 64'd0);
    check("rej_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    check("rej_err_pulse", 64'(cmd_err), 64'd0);
    check("rej_no_strobe", 64'(wr_strobe_cnt + rd_issue_cnt), 64'(strobes));
  endtask

  initial begin
    int w0;
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_read = 1'b0; cmd_bank = '0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Write happy path; a command offered mid-transfer must be ignored.
    w0 = wr_strobe_cnt;
    send_cmd(1'b0, 2'd0, 11'h010, 12'd4);
    check("loading_after_accept", 64'(loading), 64'd1);
    cmd_valid = 1'b1; cmd_len = '0;
    check("busy_cmd_ready", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("busy_no_err", 64'(cmd_err), 64'd0);
    write_words(2'd0, 11'h010, 4, 32'hA0, 1'b0, 1'b1);
    wait_done(16);
    check("write1_strobes", 64'(wr_strobe_cnt - w0), 64'd4);

    // Readback with a stall on word 2.
    read_words(2'd0, 11'h010, 4, 2, 5);

    // Top-of-bank boundary accepted, one past rejected.
    send_cmd(1'b0, 2'd1, 11'h7FE, 12'd2);
    write_words(2'd1, 11'h7FE, 2, 32'h0, 1'b1, 1'b0);
    wait_done(16);
    check("boundary_last_addr", 64'(last_wr_addr), 64'h7FF);
    bad_cmd(2'd1, 11'h7FF, 12'd2);

    // Illegal length and bank.
    bad_cmd(2'd0, 11'h000, 12'd0);
    bad_cmd(2'd2, 11'h000, 12'd1);
    bad_cmd(2'd3, 11'h100, 12'd4);

    // Reset after 2 of 8 words, with a third write in flight.
    send_cmd(1'b0, 2'd0, 11'h200, 12'd8);
    write_words(2'd0, 11'h200, 2, 32'h0, 1'b1, 1'b0);
    wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
    check("pre_rst_strobe", 64'(mem_wen), 64'(2'b10));
    #1 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    wr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
    send_cmd(1'b0, 2'd1, 11'h100, 12'd3);
    write_words(2'd1, 11'h100, 3, 32'h0, 1'b1, 1'b1);
    wait_done(16);
    read_words(2'd1, 11'h100, 3, 0, 2);
    read_words(2'd0, 11'h200, 2, -1, 0);

    // Full-depth write then a spot readback at the top.
    w0 = wr_strobe_cnt;
    send_cmd(1'b0, 2'd0, 11'h000, 12'h800);
    write_words(2'd0, 11'h000, DEPTH, 32'h0, 1'b1, 1'b0);
    wait_done(16);
    check("full_strobes", 64'(wr_strobe_cnt - w0), 64'(DEPTH));
    check("full_last_addr", 64'(last_wr_addr), 64'h7FF);
    read_words(2'd0, 11'h7FC, 4, 1, 3);

    check("wr_q_drained", 64'(exp_wr_q.size()), 64'd0);
    check("rd_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_load_controller.md
Name: mem_load_controller

Overview:
- Parametrised successor to the processor's hard-wired loading mux: a sequenced loader that owns the instruction and data RAM ports while the core is held.
- Streams words in (write mode) or out (readback/verify mode) over valid/ready handshakes for any of NUM_BANKS RAM2Kx32-style banks.
- Auto-increments the address and drives `loading` to steer the per-bank port muxes.
- Sits between the test/boot interface and the memory banks of the processor top.

Parameters:
- ADDRESS_WIDTH, 11, word address width per bank (depth = 2**ADDRESS_WIDTH)
- DATA_WIDTH, 32, memory word width
- NUM_BANKS, 2, number of memory banks (bank 0 = instruction, bank 1 = data)
- BANK_WIDTH, 1, width of bank select; must satisfy 2**BANK_WIDTH >= NUM_BANKS

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller accepts command (high only in IDLE)
- cmd_read  in  1  0 = write stream, 1 = readback stream
- cmd_bank  in  BANK_WIDTH  target bank
- cmd_addr  in  ADDRESS_WIDTH  start word address
- cmd_len  in  ADDRESS_WIDTH+1  word count, 1..2**ADDRESS_WIDTH
- cmd_err  out  1  one-cycle pulse: command rejected
- wr_valid  in  1  write word offered
- wr_ready  out  1  write word accepted
- wr_data  in  DATA_WIDTH  write word
- rd_valid  out  1  readback word available
- rd_ready  in  1  readback word consumed
- rd_data  out  DATA_WIDTH  readback word
- mem_cen  out  NUM_BANKS  per-bank chip enable, active low
- mem_wen  out  NUM_BANKS  per-bank write enable, active low
- mem_oen  out  NUM_BANKS  per-bank output enable, active low
- mem_addr  out  ADDRESS_WIDTH  shared address
- mem_datain  out  DATA_WIDTH  shared write data
- mem_dataout  in  NUM_BANKS*DATA_WIDTH  bank read data, bank b at [b*DATA_WIDTH +: DATA_WIDTH]
- loading  out  1  high while a command is in progress; drives core/port muxes
- done  out  1  one-cycle pulse after last word written or consumed

Behaviour:
- Reset values:
  - cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, cmd_err=0, done=0, loading=0
  - mem_cen/mem_wen/mem_oen all 1s, mem_addr=0, mem_datain=0
  - state=IDLE
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_HOLD, FINISH.
- IDLE:
  - On cmd_valid&cmd_ready, the command is checked.
  - Reject if cmd_len==0, cmd_bank>=NUM_BANKS, or cmd_addr+cmd_len > 2**ADDRESS_WIDTH (computed ADDRESS_WIDTH+2 wide, no wrap).
  - On reject: cmd_err pulses the next cycle and state stays IDLE.
  - Otherwise latch bank/addr/remaining count, set loading=1, and go to WRITE or RD_ISSUE.
- WRITE:
  - wr_ready=1 combinationally.
  - On wr_valid: that cycle drives mem_cen[bank]=0, mem_wen[bank]=0, mem_addr=addr, mem_datain=wr_data (all combinational from current addr); then addr+1, count-1.
  - Non-target banks are untouched (all 1).
  - When count reaches 0 after the final write, go to FINISH.
  - With wr_valid low, no memory access.
- RD_ISSUE:
  - mem_cen[bank]=0, mem_wen=1, mem_oen[bank]=0, mem_addr=addr.
  - addr+1, count-1, then RD_WAIT.
- RD_WAIT: RAM read latency is 1 cycle. Capture the selected bank's mem_dataout slice into rd_data, set rd_valid=1, go to RD_HOLD.
- RD_HOLD:
  - rd_valid and rd_data are held stable until rd_ready.
  - On handshake: rd_valid=0, then RD_ISSUE if count>0, else FINISH.
  - Throughput is one word per 3 cycles; this is accepted.
- FINISH: done=1 for one cycle, loading=0, return to IDLE with cmd_ready=1 on the following cycle.
- Command handling outside IDLE: cmd_valid is ignored (cmd_ready=0) and no cmd_err is raised.
- Address arithmetic: addr is ADDRESS_WIDTH wide. A full-depth command starting at 0 ends at 2**ADDRESS_WIDTH-1; the post-increment wrap to 0 is never used.
- Reset mid-command: rst immediately forces reset values, deasserting loading and all enables. The partial transfer is abandoned; memory contents already written are unspecified-but-retained.

Decomposition:
- Shared package `mem_load_pkg`: state encoding constants (3-bit), the port-off value (all 1s), and a function `bank_onehot_low(bank)` returning the active-low per-bank enable vector.
- One natural sub-module: `mem_load_addr_ctr`, the address/remaining-count counter with load, decrement and last-word flag.

Test Plan:
- Write happy path: write cmd bank0 addr 0x010 len 4, words 0xA0..0xA3 with wr_valid gaps → exactly 4 mem_wen[0] low strobes at addresses 0x010..0x013; bank1 enables stay 1; done pulses once; loading falls with done.
- Readback after write: read cmd bank0 addr 0x010 len 4, rd_ready held low 5 cycles on word 2 → rd_data sequence 0xA0..0xA3, rd_data stable while stalled, no extra mem_cen[0] strobes during the stall.
- Boundary: cmd addr 0x7FE len 2 accepted, writes 0x7FE and 0x7FF. cmd addr 0x7FF len 2 rejected → cmd_err pulse, loading stays 0, no memory strobe.
- Illegal commands: len 0, and bank 2 with NUM_BANKS=2 → each gives a cmd_err pulse and cmd_ready stays 1.
- Reset mid-command: rst asserted during WRITE after 2 of 8 words → all outputs return to reset values asynchronously, before the next edge. A new command after rst release succeeds.
- Full depth: len 2048 from addr 0 → 2048 writes, last at 0x7FF, done asserted exactly once.
